// File: rtl/wb_regfile_pkg.sv
// Shared CPU constants: datapath width, register-address width and the
// bit layout of the writeback control field carried by the pipeline registers.
package wb_regfile_pkg;

    localparam int CPU_DATA_W   = 32;
    localparam int CPU_REG_AW   = 5;
    localparam int WB_CTRL_W    = 2;
    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;

    // Writeback control field as it travels down the pipeline.
    typedef logic [WB_CTRL_W-1:0] wb_ctrl_t;

    // True when the control field requests a register-file write.
    function automatic logic wb_reg_write(input wb_ctrl_t ctrl);
        return ctrl[REGWRITE_BIT];
    endfunction

    // True when the writeback value comes from data memory, not the ALU.
    function automatic logic wb_mem_to_reg(input wb_ctrl_t ctrl);
        return ctrl[MEMTOREG_BIT];
    endfunction

endpackage

// File: rtl/wb_regfile_select.sv
// Writeback select: picks the writeback value, qualifies the write enable
// (register 0 is never a target) and exposes both to the forwarding unit.
module wb_select
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [WB_CTRL_W-1:0]  wb_in,
    input  logic [DATA_W-1:0]     dm_in,
    input  logic [DATA_W-1:0]     add_in,
    input  logic [CPU_REG_AW-1:0] rd_in,
    output logic                  wen,
    output logic [DATA_W-1:0]     wdata,
    output logic                  fwd_en,
    output logic [CPU_REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
);

    // Data mux and write qualification; purely combinational, zero latency.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wdata = add_in;
        wen   = 1'b0;
        if (wb_mem_to_reg(wb_in)) begin
            wdata = dm_in;
        end
        if (wb_reg_write(wb_in) && (rd_in != '0)) begin
            wen = 1'b1;
        end
    end

    assign fwd_en   = wen;
    assign fwd_rd   = rd_in;
    assign fwd_data = wdata;

endmodule

// File: rtl/wb_regfile.sv
// Pipeline register file with writeback stage: two combinational read ports
// with same-cycle write bypass, a hard-wired zero register and a count of
// committed writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int NREGS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WB_CTRL_W-1:0]  wb_in,
    input  logic [DATA_W-1:0]     dm_in,
    input  logic [DATA_W-1:0]     add_in,
    input  logic [CPU_REG_AW-1:0] rd_in,
    input  logic [CPU_REG_AW-1:0] rs_addr,
    input  logic [CPU_REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    output logic                  fwd_en,
    output logic [CPU_REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [31:0]           wr_count
);

    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] regs [NREGS];

    wb_select #(
        .DATA_W   (DATA_W)
    ) u_wb_select (
        .wb_in    (wb_in),
        .dm_in    (dm_in),
        .add_in   (add_in),
        .rd_in    (rd_in),
        .wen      (wen),
        .wdata    (wdata),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data)
    );

    // Register array and write counter; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset explicitly because software relies on
            // every architectural register reading zero after reset.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            // NOTE: state is updated with <= so all edge-triggered updates
            // see pre-edge values regardless of statement order.
            wr_count <= '0;
        end else if (wen) begin
            regs[rd_in] <= wdata;
            wr_count    <= wr_count + 32'd1;
        end
    end

    // Read port A: zero register, then same-cycle bypass, then stored value.
    always_comb begin
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wen && (rd_in == rs_addr)) begin
            rs_data = wdata;
        end else begin
            rs_data = regs[rs_addr];
        end
    end

    // Read port B: same priority as port A so equal addresses read equal data.
    always_comb begin
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wen && (rd_in == rt_addr)) begin
            rt_data = wdata;
        end else begin
            rt_data = regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against a behavioural register-file model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wb_in = 2'b00;
    logic [31:0] dm_in = '0;
    logic [31:0] add_in = '0;
    logic [4:0]  rd_in = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] wr_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    logic [31:0] m_count = '0;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_in    (wb_in),
        .dm_in    (dm_in),
        .add_in   (add_in),
        .rd_in    (rd_in),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model view of the value the writeback stage is presenting.
    function automatic logic [31:0] m_sel();
        return wb_in[0] ? dm_in : add_in;
    endfunction

    function automatic logic m_we();
        return wb_in[1] && (rd_in != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_we() && (rd_in == a)) return m_sel();
        return m_regs[a];
    endfunction

    // Drive one cycle's inputs at the falling edge, then compare every output.
    task automatic apply(input logic r, input logic [1:0] wb, input logic [31:0] dm,
                         input logic [31:0] add, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        rst = r; wb_in = wb; dm_in = dm; add_in = add;
        rd_in = rd; rs_addr = rs; rt_addr = rt;
        #1;
        check("rs_data",  rs_data,  m_read(rs));
        check("rt_data",  rt_data,  m_read(rt));
        check("fwd_en",   {31'd0, fwd_en}, {31'd0, m_we()});
        check("fwd_rd",   {27'd0, fwd_rd}, {27'd0, rd});
        check("fwd_data", fwd_data, m_sel());
        check("wr_count", wr_count, m_count);
    endtask

    // Advance through the rising edge and update the model the same way.
    task automatic edge_update();
        logic        we;
        logic [31:0] sel;
        we  = m_we();
        sel = m_sel();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_count = '0;
        end else if (we) begin
            m_regs[rd_in] = sel;
            m_count       = m_count + 32'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 'x;

        // Reset: stored contents and counter cleared.
        @(negedge clk);
        rst = 1'b1;
        edge_update();
        apply(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd1, 5'd31);
        check("reset_reg1", rs_data, 32'd0);
        check("reset_count", wr_count, 32'd0);
        edge_update();

        // ALU writeback to r5, then read it back.
        apply(1'b0, 2'b10, 32'h0, 32'h0000_1234, 5'd5, 5'd0, 5'd0);
        edge_update();
        apply(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        check("alu_wb_rs5", rs_data, 32'h0000_1234);
        check("alu_wb_count", wr_count, 32'd1);
        edge_update();

        // Load writeback to r9: forwarding sees memory data immediately.
        apply(1'b0, 2'b11, 32'hDEAD_BEEF, 32'h1, 5'd9, 5'd0, 5'd0);
        check("load_fwd_data", fwd_data, 32'hDEAD_BEEF);
        check("load_fwd_en", {31'd0, fwd_en}, 32'd1);
        edge_update();
        apply(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5);
        check("load_rs9", rs_data, 32'hDEAD_BEEF);
        edge_update();

        // Same-cycle bypass on both ports.
        apply(1'b0, 2'b10, 32'h0, 32'hCAFE_0001, 5'd7, 5'd7, 5'd7);
        check("bypass_rs", rs_data, 32'hCAFE_0001);
        check("bypass_rt", rt_data, 32'hCAFE_0001);
        edge_update();

        // r0 guard: no enable, reads zero, counter unchanged.
        apply(1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        check("r0_fwd_en", {31'd0, fwd_en}, 32'd0);
        check("r0_rs", rs_data, 32'd0);
        edge_update();
        apply(1'b0, 2'b01, 32'h1111_2222, 32'h0, 5'd3, 5'd3, 5'd0);
        check("r0_count", wr_count, 32'd3);
        edge_update();

        // MemtoReg alone (RegWrite low): no write, no count.
        apply(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        check("memtoreg_only_count", wr_count, 32'd3);
        edge_update();

        // Reset mid-operation drops a coincident write.
        apply(1'b0, 2'b10, 32'h0, 32'h55, 5'd3, 5'd0, 5'd0);
        edge_update();
        apply(1'b1, 2'b10, 32'h0, 32'h66, 5'd4, 5'd3, 5'd4);
        check("rst_pre_rs3", rs_data, 32'h55);
        edge_update();
        apply(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);
        check("rst_reg3", rs_data, 32'd0);
        check("rst_reg4", rt_data, 32'd0);
        check("rst_count", wr_count, 32'd0);
        edge_update();

        // Counter wrap.
        apply(1'b0, 2'b10, 32'h0, 32'hABCD, 5'd2, 5'd0, 5'd0);
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        m_count = 32'hFFFF_FFFF;
        check("wrap_pre", wr_count, 32'hFFFF_FFFF);
        edge_update();
        apply(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0);
        check("wrap_count", wr_count, 32'd0);
        check("wrap_reg2", rs_data, 32'hABCD);
        edge_update();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            logic [4:0] rs;
            logic [4:0] rt;
            rd = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 31));
            apply(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                  $urandom(), $urandom(), rd, rs, rt);
            edge_update();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and datapath width.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of architectural registers (address width 5).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wb_in  input  2  control from the MEM/WB stage; bit1 = RegWrite, bit0 = MemtoReg.
REQ-006 SHALL have port dm_in  input  DATA_W  data-memory read data from the MEM/WB stage.
REQ-007 SHALL have port add_in  input  DATA_W  ALU result from the MEM/WB stage.
REQ-008 SHALL have port rd_in  input  5  destination register from the MEM/WB stage.
REQ-009 SHALL have port rs_addr  input  5  read port A address, driven by decode.
REQ-010 SHALL have port rt_addr  input  5  read port B address, driven by decode.
REQ-011 SHALL have port rs_data  output  DATA_W  read port A data.
REQ-012 SHALL have port rt_data  output  DATA_W  read port B data.
REQ-013 SHALL have port fwd_en  output  1  writeback-active flag for the forwarding unit.
REQ-014 SHALL have port fwd_rd  output  5  writeback destination for the forwarding unit.
REQ-015 SHALL have port fwd_data  output  DATA_W  writeback data for the forwarding unit.
REQ-016 SHALL have port wr_count  output  32  count of committed register writes.

Function
REQ-017 SHALL select write data combinationally: dm_in when wb_in[0]=1, otherwise add_in.
REQ-018 SHALL assert the effective write enable (wen) only when wb_in[1]=1 and rd_in!=0.
REQ-019 SHALL drive fwd_en=wen, fwd_rd=rd_in and fwd_data=selected write data combinationally, with zero latency.
REQ-020 SHALL write the selected data into register rd_in at the rising clk edge when wen=1; the write is visible in array storage from the next cycle.
REQ-021 SHALL never modify register 0, and reads of address 0 SHALL return 0 regardless of writes or bypass.
REQ-022 SHALL produce combinational reads: rs_data = reg[rs_addr], rt_data = reg[rt_addr].
REQ-023 SHALL bypass internally: when wen=1 and rd_in equals a nonzero read address in the same cycle, that port SHALL return the selected write data instead of stored data.
REQ-024 SHALL serve simultaneous reads of the same address on both ports with identical data, including the bypass case.
REQ-025 SHALL increment wr_count by 1 at each clock edge where wen=1, wrapping from 0xFFFFFFFF to 0 without a flag.
REQ-026 SHALL ignore wb_in[0] when wb_in[1]=0: no write and no count.

Reset
REQ-027 SHALL clear all registers and wr_count to 0 at a rising clk edge while rst=1.
REQ-028 SHALL suppress writes during reset: a write presented in a cycle with rst=1 SHALL be dropped and not counted.
REQ-029 SHALL keep read outputs combinational during reset, reflecting stored contents plus bypass; after the reset edge, stored contents SHALL be 0.

Structure
REQ-030 SHALL source the WB bit positions (REGWRITE_BIT=1, MEMTOREG_BIT=0), DATA_W and the register-address width from the shared CPU package also used by the pipeline registers.
REQ-031 SHALL isolate the write-data mux plus the wen/fwd_* logic in one sub-module, wb_select; the register array, bypass and counter SHALL reside in wb_regfile.

Verification
REQ-032 SHALL cover ALU writeback: wb_in=2'b10, add_in=0x0000_1234, rd_in=5 for one cycle, then rs_addr=5 -> rs_data=0x0000_1234 and wr_count=1.
REQ-033 SHALL cover load writeback: wb_in=2'b11, dm_in=0xDEAD_BEEF, add_in=0x1, rd_in=9 -> reg9=0xDEAD_BEEF, fwd_data=0xDEAD_BEEF in the same cycle.
REQ-034 SHALL cover same-cycle bypass: wb_in=2'b10, add_in=0xCAFE_0001, rd_in=7, rs_addr=rt_addr=7 -> rs_data=rt_data=0xCAFE_0001 before the clock edge.
REQ-035 SHALL cover the r0 guard: wb_in=2'b10, add_in=0xFFFF_FFFF, rd_in=0 -> fwd_en=0, rs_data(addr 0)=0, wr_count unchanged.
REQ-036 SHALL cover reset mid-operation: write reg3=0x55, then assert rst=1 for one cycle together with a write of reg4=0x66 -> reg3=0, reg4=0, wr_count=0.
REQ-037 SHALL cover counter wrap: force wr_count=0xFFFF_FFFF, perform one valid write -> wr_count=0.
